// File: rtl/cnt_delta_pkg.sv
// cnt_delta_pkg
//   Shared types and helpers for the cnt_delta_drain block.
//   - cnt_delta_state_e : consumer FSM states (INIT, IDLE, BUSY)
//   - sat_add           : unsigned add that saturates at 2^bw-1
package cnt_delta_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2
  } cnt_delta_state_e;

  // Saturating add on bw-bit quantities carried in 32-bit containers.
  // The caller truncates the result back to bw bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned bw);
    logic [32:0] s;
    logic [32:0] max_v;
    s     = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << bw) - 33'd1;
    return (s > max_v) ? max_v[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/cnt_delta_win_timer.sv
// cnt_delta_win_timer
//   Free-running window counter 0..WIN-1 with a strobe on the last cycle.
//   The counter is held at 0 while en is low.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : run enable (low holds the count at 0)
//     last       : high during the final cycle of each window
module cnt_delta_win_timer #(
  parameter int WIN = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic last
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CW-1:0] LAST_V = CW'(WIN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST_V) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = en && (cnt == LAST_V);

endmodule

// File: rtl/cnt_delta_drain.sv
// cnt_delta_drain
//   Receiving-domain consumer of a synchronized binary event count. Each cycle
//   the modular increment of cnt_in is added to a saturating backlog, which is
//   drained one event per valid/ready handshake.
//
//   Handshake: ev_valid is high whenever backlog > 0 and never drops while
//   events are pending; an event is consumed on every cycle where
//   ev_valid & ev_ready is high at the rising edge of clk.
//
//   Optional macro CNT_DELTA_RATE_EN adds a windowed event-rate measurement
//   (ports rate, rate_upd); without it those ports and their logic are absent.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     cnt_in     : synchronized event count, monotonic modulo 2^W
//     ev_valid   : one event pending
//     ev_ready   : consumer accepts an event
//     backlog    : registered pending-event count
//     ovf        : sticky overflow, events lost at saturation
//     clr_ovf    : synchronous clear of ovf (a same-cycle overflow wins)
//     rate       : events in last completed window (CNT_DELTA_RATE_EN)
//     rate_upd   : one-cycle strobe when rate updates (CNT_DELTA_RATE_EN)
//     state_dbg  : current FSM state
module cnt_delta_drain
  import cnt_delta_pkg::*;
#(
  parameter int W   = 8,
  parameter int BW  = 12,
  parameter int WIN = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     cnt_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [BW-1:0]    backlog,
  output logic             ovf,
  input  logic             clr_ovf,
`ifdef CNT_DELTA_RATE_EN
  output logic [BW-1:0]    rate,
  output logic             rate_upd,
`endif
  output cnt_delta_state_e state_dbg
);

  if (W > BW || WIN < 2) begin : g_bad_params
    $error("cnt_delta_drain: need W <= BW and WIN >= 2");
  end

  localparam logic [BW:0] BL_MAX = {1'b0, {BW{1'b1}}};

  cnt_delta_state_e state;
  logic [W-1:0]     cnt_last;
  logic [W-1:0]     delta;
  logic             take;
  logic [BW:0]      sum;
  logic             sat;
  logic [BW-1:0]    backlog_nxt;

  // Subtraction modulo 2^W handles counter wrap (e.g. 250 -> 3 gives 9).
  // sum cannot underflow: take is only possible while backlog > 0.
  always_comb begin
    delta       = cnt_in - cnt_last;
    take        = ev_valid & ev_ready;
    sum         = {1'b0, backlog} + (BW+1)'(delta) - (BW+1)'(take);
    sat         = (sum > BL_MAX);
    backlog_nxt = sat ? BL_MAX[BW-1:0] : sum[BW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt_last <= '0;
      backlog  <= '0;
      ovf      <= 1'b0;
    end else begin
      cnt_last <= cnt_in;
      if (state == INIT) begin
        // Adopt the upstream count as-is so a nonzero start is not a burst.
        state <= IDLE;
        if (clr_ovf) ovf <= 1'b0;
      end else begin
        backlog <= backlog_nxt;
        state   <= (backlog_nxt != '0) ? BUSY : IDLE;
        if (sat) begin
          ovf <= 1'b1;
        end else if (clr_ovf) begin
          ovf <= 1'b0;
        end
      end
    end
  end

  assign ev_valid  = (state == BUSY);
  assign state_dbg = state;

`ifdef CNT_DELTA_RATE_EN
  logic          timer_en;
  logic          win_last;
  logic [BW-1:0] acc;
  logic [BW-1:0] acc_plus;

  assign timer_en = (state != INIT);
  assign acc_plus = BW'(sat_add(32'(acc), 32'(delta), BW));

  cnt_delta_win_timer #(.WIN(WIN)) u_win_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (timer_en),
    .last  (win_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rate     <= '0;
      rate_upd <= 1'b0;
    end else begin
      rate_upd <= 1'b0;
      if (timer_en) begin
        if (win_last) begin
          rate     <= acc_plus;
          rate_upd <= 1'b1;
          acc      <= '0;
        end else begin
          acc <= acc_plus;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cnt_delta_drain.sv
module tb_cnt_delta_drain;
  import cnt_delta_pkg::*;

  localparam int W   = 8;
  localparam int BW  = 12;
  localparam int WIN = 100;
  localparam int BL_MAX = (1 << BW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]     cnt_in = '0;
  logic             ev_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             ev_valid;
  logic [BW-1:0]    backlog;
  logic             ovf;
  cnt_delta_state_e state_dbg;
`ifdef CNT_DELTA_RATE_EN
  logic [BW-1:0]    rate;
  logic             rate_upd;
`endif

  cnt_delta_drain #(.W(W), .BW(BW), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_in    (cnt_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .backlog   (backlog),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
`ifdef CNT_DELTA_RATE_EN
    .rate      (rate),
    .rate_upd  (rate_upd),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending-event count as a plain integer.
  int       m_bl;
  bit       m_ovf;
  bit       m_init;
  logic [W-1:0] m_last;
  int       m_n, m_acc, m_rate;
  bit       m_upd;

  task automatic model_reset();
    m_bl = 0; m_ovf = 0; m_init = 1; m_last = '0;
    m_n = 0; m_acc = 0; m_rate = 0; m_upd = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [W-1:0] c, input logic rdy, input logic clr);
    int d, s, take;
    m_upd = 0;
    if (m_init) begin
      m_last = c;
      m_init = 0;
      if (clr) m_ovf = 0;
    end else begin
      d = (int'(c) - int'(m_last) + (1 << W)) % (1 << W);
      m_last = c;
      take = (m_bl > 0 && rdy) ? 1 : 0;
      s = m_bl + d - take;
      if (s > BL_MAX) begin
        m_bl = BL_MAX;
        m_ovf = 1;
      end else begin
        m_bl = s;
        if (clr) m_ovf = 0;
      end
      // Rate: the WIN-th, 2*WIN-th ... post-initialisation cycle closes a window.
      m_n++;
      m_acc = (m_acc + d > BL_MAX) ? BL_MAX : m_acc + d;
      if (m_n % WIN == 0) begin
        m_rate = m_acc;
        m_upd = 1;
        m_acc = 0;
      end
    end
    exp_q.push_back(m_bl[BW-1:0]);
  endtask

  task automatic compare();
    logic [BW-1:0] exp_bl;
    exp_bl = exp_q.pop_front();
    check("backlog", 32'(backlog), 32'(exp_bl));
    check("ev_valid", 32'(ev_valid), (m_bl > 0) ? 32'd1 : 32'd0);
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("state", 32'(state_dbg), (m_bl > 0) ? 32'(BUSY) : 32'(IDLE));
`ifdef CNT_DELTA_RATE_EN
    check("rate_upd", 32'(rate_upd), 32'(m_upd));
    check("rate", 32'(rate), 32'(m_rate));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [W-1:0] c, input logic rdy, input logic clr);
    cnt_in   = c;
    ev_ready = rdy;
    clr_ovf  = clr;
    @(posedge clk);
    model_edge(c, rdy, clr);
    #1;
    compare();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_backlog"}, 32'(backlog), 32'd0);
    check({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(INIT));
`ifdef CNT_DELTA_RATE_EN
    check({tag, "_rate"}, 32'(rate), 32'd0);
    check({tag, "_rate_upd"}, 32'(rate_upd), 32'd0);
`endif
  endtask

  // Asynchronous reset pulse applied away from the clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] c;

  initial begin
    model_reset();
    cnt_in = 8'd37;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // Nonzero upstream count at reset release must not create events.
    repeat (3) step(8'd37, 1'b0, 1'b0);
    check("init_no_burst", 32'(backlog), 32'd0);

    // +5 with ready held: backlog 5, then five back-to-back handshakes.
    step(8'd42, 1'b1, 1'b0);
    check("step5_backlog", 32'(backlog), 32'd5);
    repeat (5) step(8'd42, 1'b1, 1'b0);
    check("step5_drained", 32'(backlog), 32'd0);
    check("step5_idle", 32'(ev_valid), 32'd0);

    // Wrap-around 250 -> 3 with no ready.
    step(8'd250, 1'b1, 1'b0);
    repeat (208) step(8'd250, 1'b1, 1'b0);
    step(8'd3, 1'b0, 1'b0);
    check("wrap_backlog", 32'(backlog), 32'd9);
    step(8'd3, 1'b0, 1'b0);
    check("wrap_valid_held", 32'(ev_valid), 32'd1);

    // Arrival and take in the same cycle: 4 + 2 - 1 = 5.
    repeat (5) step(8'd3, 1'b1, 1'b0);
    check("pre_simul", 32'(backlog), 32'd4);
    step(8'd5, 1'b1, 1'b0);
    check("simul_backlog", 32'(backlog), 32'd5);
    repeat (5) step(8'd5, 1'b1, 1'b0);

    // Saturation at 4095 and sticky overflow.
    c = 8'd5;
    repeat (16) begin
      c = c + 8'd255;
      step(c, 1'b0, 1'b0);
    end
    c = c + 8'd10;
    step(c, 1'b0, 1'b0);
    check("near_full", 32'(backlog), 32'd4090);
    c = c + 8'd10;
    step(c, 1'b0, 1'b0);
    check("sat_backlog", 32'(backlog), 32'd4095);
    check("sat_ovf", 32'(ovf), 32'd1);
    c = c + 8'd5;
    step(c, 1'b0, 1'b1);
    check("clr_vs_sat_ovf", 32'(ovf), 32'd1);
    step(c, 1'b1, 1'b1);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_backlog", 32'(backlog), 32'd4094);

    // Reset in the middle of a large backlog.
    async_reset("midop");

    // Randomized traffic, alternating heavy and light phases.
    c = $urandom_range(0, 255);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic rdy, clr;
      r = $urandom_range(0, 99);
      if ((i / 200) % 2 == 0) begin
        if (r < 2)       c = c + 8'($urandom_range(0, 255));
        else if (r < 60) c = c + 8'($urandom_range(1, 3));
      end else begin
        if (r < 40)      c = c + 8'd1;
      end
      rdy = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 99) < 3);
      step(c, rdy, clr);
    end

`ifdef CNT_DELTA_RATE_EN
    // Three events every ten cycles: rate 30 per 100-cycle window.
    async_reset("rate_pre");
    for (int i = 0; i < 350; i++) begin
      if (i > 0 && (i % 10) < 3) c = c + 8'd1;
      step(c, 1'b1, 1'b0);
      if (m_upd) check("rate_30", 32'(rate), 32'd30);
    end
    async_reset("rate_midwin");
    for (int i = 0; i < 20; i++) begin
      c = c + 8'd1;
      step(c, 1'b1, 1'b0);
    end
`endif

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_leftover: got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
